// File: rtl/wb_arb_pkg.sv
// Shared types for the N-port Wishbone slave arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_arb_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // One-hot (up to 8 ports) to binary index; zero input maps to index 0.
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arb_rr.sv
// Request vector to one-hot grant: fixed lowest-index or round-robin after last owner.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is taken.
module wb_arb_rr
    import wb_arb_pkg::*;
#(
    parameter int NM = 2
) (
    input  logic [NM-1:0] req_i,
    input  logic [NM-1:0] last_grant_i,
    input  logic          mode_i,
    output logic [NM-1:0] gnt_o
);

    logic [2:0]    last_idx;
    logic [3:0]    start;
    logic [NM-1:0] rot;
    logic [NM-1:0] pick;

    // Rotate requests so the search origin sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        last_idx = oh2idx(8'(last_grant_i));
        start    = 4'd0;
        if (mode_i == ARB_RR && |last_grant_i) begin
            start = {1'b0, last_idx} + 4'd1;
            if (start == 4'(NM)) start = 4'd0;
        end
        rot   = NM'({req_i, req_i} >> start);
        pick  = rot & (~rot + NM'(1));
        gnt_o = NM'(({pick, pick} << start) >> NM);
    end

endmodule

// File: rtl/wb_slave_arb_nport.sv
// Grants one of NM Wishbone masters a whole cycle on a single slave, with a stalled-access watchdog.
// Latency: 1 cycle from cyc to grant out of idle; handover to a waiting master on the owner's cyc-drop edge.
// Backpressure: owner holds the slave until it drops cyc; others wait with zero responses.
module wb_slave_arb_nport
    import wb_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int NM       = 2,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0,
    parameter int USE_ARB  = 1,
    localparam int SW      = DW / 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*DW-1:0] m_dat_i,
    input  logic [NM*SW-1:0] m_sel_i,
    input  logic [NM*3-1:0]  m_cti_i,
    input  logic [NM*2-1:0]  m_bte_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NM-1:0]    m_rty_o,
    output logic [NM*DW-1:0] m_dat_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [SW-1:0]    s_sel_o,
    output logic [2:0]       s_cti_o,
    output logic [1:0]       s_bte_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    input  logic [DW-1:0]    s_dat_i,
    output logic [NM-1:0]    grant_o,
    output logic             timeout_o
);

    localparam int   CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic WD_EN = (TIMEOUT > 0);
    localparam logic MODE  = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

    arb_state_e    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [NM-1:0] last_q, last_d;
    logic [CW-1:0] wd_q, wd_d;
    logic          blk_q, blk_d;

    logic [NM-1:0] arb_req, arb_gnt;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;
    logic [SW-1:0] own_sel;
    logic [2:0]    own_cti;
    logic [1:0]    own_bte;
    logic          own_cyc, own_stb, own_we;
    logic          active, own_req_stb, resp, fire;

    // The current owner never competes for its own handover.
    assign arb_req = m_cyc_i & ~grant_q;

    wb_arb_rr #(.NM(NM)) u_arb (
        .req_i        (arb_req),
        .last_grant_i (last_q),
        .mode_i       (MODE),
        .gnt_o        (arb_gnt)
    );

    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_cti = '0;
        own_bte = '0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (grant_q[k]) begin
                own_adr = own_adr | m_adr_i[k*AW +: AW];
                own_dat = own_dat | m_dat_i[k*DW +: DW];
                own_sel = own_sel | m_sel_i[k*SW +: SW];
                own_cti = own_cti | m_cti_i[k*3 +: 3];
                own_bte = own_bte | m_bte_i[k*2 +: 2];
                own_cyc = own_cyc | m_cyc_i[k];
                own_stb = own_stb | m_stb_i[k];
                own_we  = own_we  | m_we_i[k];
            end
        end
    end

    // blk_q hides the slave from the owner after a forced err until the owner releases stb.
    assign active      = own_cyc & ~blk_q;
    assign own_req_stb = active & own_stb;
    assign resp        = s_ack_i | s_err_i | s_rty_i;
    assign fire        = WD_EN & own_req_stb & ~resp & (wd_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|arb_req) begin
                    state_d = GRANT;
                    grant_d = arb_gnt;
                    last_d  = arb_gnt;
                end
            end
            GRANT: begin
                if (!own_cyc) begin
                    if (|arb_req) begin
                        grant_d = arb_gnt;
                        last_d  = arb_gnt;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        wd_d  = '0;
        blk_d = blk_q;
        if (WD_EN && own_req_stb && !resp && !fire) wd_d = wd_q + CW'(1);
        if (fire) blk_d = 1'b1;
        else if (!own_cyc || !own_stb) blk_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= '0;
            wd_q    <= '0;
            blk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        m_dat_o = '0;
        if (USE_ARB == 0) begin
            s_adr_o   = m_adr_i[AW-1:0];
            s_dat_o   = m_dat_i[DW-1:0];
            s_sel_o   = m_sel_i[SW-1:0];
            s_cti_o   = m_cti_i[2:0];
            s_bte_o   = m_bte_i[1:0];
            s_cyc_o   = m_cyc_i[0];
            s_stb_o   = m_stb_i[0];
            s_we_o    = m_we_i[0];
            m_ack_o   = NM'(s_ack_i);
            m_err_o   = NM'(s_err_i);
            m_rty_o   = NM'(s_rty_i);
            m_dat_o[DW-1:0] = s_dat_i;
            grant_o   = '0;
            timeout_o = 1'b0;
        end else begin
            s_adr_o   = own_adr;
            s_dat_o   = own_dat;
            s_sel_o   = own_sel;
            s_cti_o   = own_cti;
            s_bte_o   = own_bte;
            s_cyc_o   = own_cyc;
            s_stb_o   = own_req_stb & ~fire;
            s_we_o    = own_we;
            m_ack_o   = grant_q & {NM{active & s_ack_i}};
            m_err_o   = grant_q & {NM{active & (s_err_i | fire)}};
            m_rty_o   = grant_q & {NM{active & s_rty_i}};
            for (int k = 0; k < NM; k++) begin
                if (active && grant_q[k]) m_dat_o[k*DW +: DW] = s_dat_i;
            end
            grant_o   = grant_q;
            timeout_o = fire;
        end
    end

endmodule
